// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_pkg
// Brief  : Shared SPI link types and constants for the monarch/serf pair.
// Rev    : 1.0  initial release
// ============================================================================
package spi_pkg;

   localparam int SPI_FRAME_BITS = 16;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } serf_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module : spi_sync_edge
// Brief  : Multi-flop input synchronizer with registered rise/fall pulses.
// Rev    : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_synced;

   assign w_synced = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= {SYNC_STAGES{RESET_VAL}};
         r_prev <= RESET_VAL;
         o_rise <= 1'b0;
         o_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
         r_prev <= w_synced;
         o_rise <= w_synced & ~r_prev;
         o_fall <= ~w_synced & r_prev;
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_serf.sv
`default_nettype none
// ============================================================================
// Module : spi_serf
// Brief  : Mode-3, MSB-first SPI responder, fully oversampled on clk.
// Rev    : 1.0  initial release
// ============================================================================
module spi_serf
   import spi_pkg::*;
#(
   parameter int FRAME_BITS  = SPI_FRAME_BITS,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  SS_n,
   input  logic                  SCLK,
   input  logic                  MOSI,
   output logic                  MISO,
   input  logic [FRAME_BITS-1:0] tx_data,
   output logic [FRAME_BITS-1:0] rx_data,
   output logic                  rdy,
   input  logic                  clr_rdy,
   output logic                  frm_err
);

   localparam logic [4:0] C_FRAME_CNT = 5'(FRAME_BITS);
   localparam logic [4:0] C_CNT_MAX   = 5'd31;

   logic                   w_rise_ss;
   logic                   w_fall_ss;
   logic                   w_rise_sclk;
   logic                   w_fall_sclk;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   w_mosi;

   serf_state_t            r_state;
   logic [4:0]             r_bit_cnt;
   logic [FRAME_BITS-1:0]  r_rx_shft;
   logic [FRAME_BITS-1:0]  r_tx_shft;
   logic [4:0]             w_cnt_next;
   logic [FRAME_BITS-1:0]  w_rx_next;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
      .clk    (clk),
      .rst    (rst),
      .i_d    (SS_n),
      .o_rise (w_rise_ss),
      .o_fall (w_fall_ss)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
      .clk    (clk),
      .rst    (rst),
      .i_d    (SCLK),
      .o_rise (w_rise_sclk),
      .o_fall (w_fall_sclk)
   );

   always_ff @(posedge clk) begin
      if (rst) r_mosi_sync <= '0;
      else     r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
   end

   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
   assign MISO   = r_tx_shft[FRAME_BITS-1];

   // Next-state view including a bit arriving this cycle, so a rise_SS that
   // lands together with the last rise_SCLK still sees a complete frame.
   always_comb begin
      w_cnt_next = r_bit_cnt;
      w_rx_next  = r_rx_shft;
      if (w_rise_sclk) begin
         w_rx_next  = {r_rx_shft[FRAME_BITS-2:0], w_mosi};
         w_cnt_next = (r_bit_cnt == C_CNT_MAX) ? r_bit_cnt : r_bit_cnt + 5'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_bit_cnt <= 5'd0;
         r_rx_shft <= '0;
         r_tx_shft <= '0;
         rx_data   <= '0;
         rdy       <= 1'b0;
         frm_err   <= 1'b0;
      end else begin
         frm_err <= 1'b0;
         if (clr_rdy) rdy <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_fall_ss) begin
                  r_tx_shft <= tx_data;
                  r_bit_cnt <= 5'd0;
                  rdy       <= 1'b0;
                  r_state   <= ACTIVE;
               end
            end
            ACTIVE: begin
               r_rx_shft <= w_rx_next;
               r_bit_cnt <= w_cnt_next;
               // The leading SCLK fall precedes any sample; MSB is already on MISO.
               if (w_fall_sclk && (r_bit_cnt != 5'd0))
                  r_tx_shft <= {r_tx_shft[FRAME_BITS-2:0], 1'b0};
               if (w_rise_ss) begin
                  if (w_cnt_next == C_FRAME_CNT) begin
                     rx_data <= w_rx_next;
                     rdy     <= 1'b1;
                  end else begin
                     frm_err <= 1'b1;
                  end
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_serf.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_serf
// Brief  : Directed self-checking bench driving spi_serf as an SPI monarch.
// Rev    : 1.0  initial release
// ============================================================================
module tb_spi_serf;

   logic        clk = 1'b0;
   logic        rst;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;
   logic [15:0] tx_data;
   logic [15:0] rx_data;
   logic        rdy;
   logic        clr_rdy;
   logic        frm_err;

   int          n_pass     = 0;
   int          n_total    = 0;
   int          err_cycles = 0;
   logic [15:0] rd;

   spi_serf #(.FRAME_BITS(16), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .SS_n    (SS_n),
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .MISO    (MISO),
      .tx_data (tx_data),
      .rx_data (rx_data),
      .rdy     (rdy),
      .clr_rdy (clr_rdy),
      .frm_err (frm_err)
   );

   always #5 clk = ~clk;

   // Every high cycle of frm_err is counted, so a stretched pulse shows up.
   always @(negedge clk) if (frm_err === 1'b1) err_cycles++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ss_low();
      SS_n = 1'b0;
      wait_clk(8);
   endtask

   task automatic ss_high();
      SS_n = 1'b1;
   endtask

   // Mode 3: drive MOSI on the SCLK fall, sample MISO just before the rise.
   task automatic send_bits(input logic [15:0] w, input int n,
                            input logic [15:0] tx_mid, output logic [15:0] r);
      r = 16'h0000;
      for (int i = 0; i < n; i++) begin
         SCLK = 1'b0;
         MOSI = (i < 16) ? w[4'(15 - i)] : 1'b0;
         if (i == 8) tx_data = tx_mid;
         wait_clk(8);
         r    = {r[14:0], MISO};
         SCLK = 1'b1;
         wait_clk(8);
      end
   endtask

   initial begin
      rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
      tx_data = 16'h0000; clr_rdy = 1'b0;
      wait_clk(4);
      rst = 1'b0;
      wait_clk(1);
      chk("reset_miso",    {31'd0, MISO},    32'd0);
      chk("reset_rx_data", {16'd0, rx_data}, 32'd0);
      chk("reset_rdy",     {31'd0, rdy},     32'd0);
      chk("reset_frm_err", {31'd0, frm_err}, 32'd0);

      // Basic full-duplex frame
      tx_data = 16'h3C96;
      ss_low();
      send_bits(16'hA5C3, 16, 16'h3C96, rd);
      ss_high();
      wait_clk(8);
      chk("f1_rx_data", {16'd0, rx_data}, 32'h0000A5C3);
      chk("f1_rdy",     {31'd0, rdy},     32'd1);
      chk("f1_miso_rd", {16'd0, rd},      32'h00003C96);
      chk("f1_no_err",  err_cycles,       32'd0);

      // Back-to-back frames without clr_rdy
      tx_data = 16'h0000;
      ss_low();
      send_bits(16'h0001, 16, 16'h0000, rd);
      ss_high();
      wait_clk(8);
      chk("b2b1_rx_data", {16'd0, rx_data}, 32'h00000001);
      chk("b2b1_rdy",     {31'd0, rdy},     32'd1);
      ss_low();
      chk("b2b2_rdy_drop", {31'd0, rdy}, 32'd0);
      send_bits(16'h8000, 16, 16'h0000, rd);
      ss_high();
      wait_clk(8);
      chk("b2b2_rx_data", {16'd0, rx_data}, 32'h00008000);
      chk("b2b2_rdy",     {31'd0, rdy},     32'd1);

      // Short frame: 9 rises
      ss_low();
      send_bits(16'hFFFF, 9, 16'h0000, rd);
      ss_high();
      wait_clk(8);
      chk("short_err_cycles", err_cycles,       32'd1);
      chk("short_rdy",        {31'd0, rdy},     32'd0);
      chk("short_rx_kept",    {16'd0, rx_data}, 32'h00008000);

      // SS_n pulse with zero rises
      ss_low();
      ss_high();
      wait_clk(8);
      chk("zero_err_cycles", err_cycles,       32'd2);
      chk("zero_rx_kept",    {16'd0, rx_data}, 32'h00008000);

      // Long frame: 20 rises
      ss_low();
      send_bits(16'h1111, 20, 16'h0000, rd);
      ss_high();
      wait_clk(8);
      chk("long_err_cycles", err_cycles,       32'd3);
      chk("long_rx_kept",    {16'd0, rx_data}, 32'h00008000);
      chk("long_rdy",        {31'd0, rdy},     32'd0);

      // clr_rdy in the exact cycle rdy sets (4 clk after the SS_n rise)
      ss_low();
      send_bits(16'h0F0F, 16, 16'h0000, rd);
      ss_high();
      wait_clk(3);
      chk("lat_rdy_not_yet", {31'd0, rdy}, 32'd0);
      clr_rdy = 1'b1;
      wait_clk(1);
      clr_rdy = 1'b0;
      chk("set_wins_rdy",  {31'd0, rdy},     32'd1);
      chk("set_wins_rx",   {16'd0, rx_data}, 32'h00000F0F);
      clr_rdy = 1'b1;
      wait_clk(1);
      clr_rdy = 1'b0;
      chk("clr_rdy_clears", {31'd0, rdy}, 32'd0);

      // Reset mid-frame after 8 bits
      tx_data = 16'hFFFF;
      ss_low();
      send_bits(16'hFFFF, 8, 16'hFFFF, rd);
      chk("mid_miso_high", {31'd0, MISO}, 32'd1);
      rst = 1'b1; SS_n = 1'b1;
      wait_clk(1);
      chk("rst_mid_miso",    {31'd0, MISO},    32'd0);
      chk("rst_mid_rx_data", {16'd0, rx_data}, 32'd0);
      chk("rst_mid_rdy",     {31'd0, rdy},     32'd0);
      chk("rst_mid_frm_err", {31'd0, frm_err}, 32'd0);
      wait_clk(4);
      rst = 1'b0;
      wait_clk(8);
      chk("rst_mid_no_err", err_cycles, 32'd3);
      tx_data = 16'h0000;
      ss_low();
      send_bits(16'h1234, 16, 16'h0000, rd);
      ss_high();
      wait_clk(8);
      chk("post_rst_rx_data", {16'd0, rx_data}, 32'h00001234);
      chk("post_rst_rdy",     {31'd0, rdy},     32'd1);

      // tx_data changes mid-frame; response was captured at frame start
      tx_data = 16'hAAAA;
      ss_low();
      chk("miso_msb_at_start", {31'd0, MISO}, 32'd1);
      send_bits(16'hC0DE, 16, 16'h5555, rd);
      ss_high();
      wait_clk(8);
      chk("txcap_miso_rd", {16'd0, rd},      32'h0000AAAA);
      chk("txcap_rx_data", {16'd0, rx_data}, 32'h0000C0DE);
      chk("final_err_cycles", err_cycles,    32'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
